// File: rtl/dmux_16_stream.sv
// Two-way stream demultiplexer. Each output channel has a 2-entry FIFO.
// Define DMUX_16_STREAM_COUNT_EN to enable the 8-bit output-transfer counters.
module dmux_16_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  // Index 0 is channel A and index 1 is channel B. The pointer MSB is the wrap bit.
  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [PTR_W-1:0] rd_ptr_d [2];

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] sink_ready;

  assign sink_ready = {b_ready, a_ready};

  // NOTE: every signal written here is given a value on every path, so no latch is inferred.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int ch = 0; ch < 2; ch++) begin
      empty[ch] = (wr_ptr_q[ch] == rd_ptr_q[ch]);
      full[ch]  = (wr_ptr_q[ch][ADDR_W] != rd_ptr_q[ch][ADDR_W]) &&
                  (wr_ptr_q[ch][ADDR_W-1:0] == rd_ptr_q[ch][ADDR_W-1:0]);
    end
  end

  // No bypass: a full FIFO blocks input even when its sink pops this cycle.
  assign in_ready = ~full[in_sel];

  always_comb begin
    push    = '0;
    pop     = '0;
    push[0] = in_valid && in_ready && !in_sel;
    push[1] = in_valid && in_ready &&  in_sel;
    for (int ch = 0; ch < 2; ch++) begin
      pop[ch]      = !empty[ch] && sink_ready[ch];
      wr_ptr_d[ch] = wr_ptr_q[ch] + PTR_W'(push[ch]);
      rd_ptr_d[ch] = rd_ptr_q[ch] + PTR_W'(pop[ch]);
    end
  end

  // NOTE: storage is cleared on reset so that a_data/b_data read back as zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        wr_ptr_q[ch] <= '0;
        rd_ptr_q[ch] <= '0;
        for (int e = 0; e < DEPTH; e++) mem_q[ch][e] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      for (int ch = 0; ch < 2; ch++) begin
        if (push[ch]) mem_q[ch][wr_ptr_q[ch][ADDR_W-1:0]] <= in_data;
        wr_ptr_q[ch] <= wr_ptr_d[ch];
        rd_ptr_q[ch] <= rd_ptr_d[ch];
      end
    end
  end

  assign a_data  = mem_q[0][rd_ptr_q[0][ADDR_W-1:0]];
  assign b_data  = mem_q[1][rd_ptr_q[1][ADDR_W-1:0]];
  assign a_valid = ~empty[0];
  assign b_valid = ~empty[1];

`ifdef DMUX_16_STREAM_COUNT_EN
  logic [7:0] a_count_q, a_count_d;
  logic [7:0] b_count_q, b_count_d;

  // The counters wrap naturally from 255 to 0.
  assign a_count_d = a_count_q + 8'(pop[0]);
  assign b_count_d = b_count_q + 8'(pop[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;
`else
  assign a_count = '0;
  assign b_count = '0;
`endif

endmodule
